// File: rtl/router_dest_fifo.sv
// rtl/router_dest_fifo.sv - destination byte FIFO with packet tracking and unread-timeout flush
module router_dest_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              soft_reset,
    output logic              pkt_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = DATA_W - 1;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] REM_ONE  = RW'(1);

    typedef enum logic {
        RD_IDLE,
        RD_PKT
    } rd_state_e;

    // Each entry carries the header flag alongside the byte.
    logic [DATA_W:0]   mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [RW-1:0]     pkt_rem_q, pkt_rem_d;
    rd_state_e         state_q, state_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              soft_reset_q, soft_reset_d;
    logic              pkt_done_q, pkt_done_d;

    logic              push, pop, wr_fire, tmo_cond, flush;
    logic [DATA_W:0]   rd_entry;
    logic [DATA_W-3:0] rd_len;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_FULL);
    assign valid_out  = ~empty;
    assign data_out   = data_out_q;
    assign soft_reset = soft_reset_q;
    assign pkt_done   = pkt_done_q;

    assign push     = write_enb & ~full;
    assign pop      = read_enb & ~empty;
    assign tmo_cond = valid_out & ~read_enb;
    assign flush    = tmo_cond & (tmo_q == TMO_LAST);
    assign wr_fire  = push & ~flush;
    assign rd_entry = mem_q[rd_ptr_q];
    assign rd_len   = rd_entry[DATA_W-1:2];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        pkt_rem_d    = pkt_rem_q;
        state_d      = state_q;
        data_out_d   = data_out_q;
        soft_reset_d = 1'b0;
        pkt_done_d   = 1'b0;
        tmo_d        = tmo_cond ? (tmo_q + TMO_ONE) : '0;

        if (flush) begin
            // Flush drops any push or pop presented in the same cycle.
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            pkt_rem_d    = '0;
            state_d      = RD_IDLE;
            data_out_d   = '0;
            tmo_d        = '0;
            soft_reset_d = 1'b1;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = rd_entry[DATA_W-1:0];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            if (pop) begin
                if (rd_entry[DATA_W]) begin
                    // A header always (re)starts a packet: payload length plus parity.
                    state_d   = RD_PKT;
                    pkt_rem_d = RW'(rd_len) + REM_ONE;
                end else if (state_q == RD_PKT) begin
                    if (pkt_rem_q == REM_ONE) begin
                        state_d    = RD_IDLE;
                        pkt_rem_d  = '0;
                        pkt_done_d = 1'b1;
                    end else begin
                        pkt_rem_d = pkt_rem_q - REM_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tmo_q        <= '0;
            pkt_rem_q    <= '0;
            state_q      <= RD_IDLE;
            data_out_q   <= '0;
            soft_reset_q <= 1'b0;
            pkt_done_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tmo_q        <= tmo_d;
            pkt_rem_q    <= pkt_rem_d;
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            soft_reset_q <= soft_reset_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= {lfd_state, data_in};
        end
    end

endmodule

// File: tb/tb_router_dest_fifo.sv
// tb/tb_router_dest_fifo.sv - scoreboard bench for router_dest_fifo
module tb_router_dest_fifo;

    localparam int DW      = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          write_enb = 1'b0;
    logic          lfd_state = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          read_enb = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out, full, empty, soft_reset, pkt_done;

    router_dest_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .full       (full),
        .empty      (empty),
        .soft_reset (soft_reset),
        .pkt_done   (pkt_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected-data queue and occupancy, updated from the stimulus at each edge.
    logic [DW-1:0] exp_q[$];
    int            mcnt = 0;
    int            mtmo = 0;
    bit            mon_en = 1'b0;
    bit            pend_valid = 1'b0;
    bit            pend_flush = 1'b0;
    logic [DW-1:0] pend_data = '0;

    always @(posedge clock) begin
        bit p_pop;
        bit p_push;
        if (reset) begin
            exp_q.delete();
            mcnt = 0;
            mtmo = 0;
        end else if (mcnt != 0 && !read_enb && mtmo == TIMEOUT - 1) begin
            exp_q.delete();
            mcnt = 0;
            mtmo = 0;
            pend_flush = 1'b1;
        end else begin
            p_pop  = read_enb && mcnt != 0;
            p_push = write_enb && mcnt != DEPTH;
            mtmo   = (mcnt != 0 && !read_enb) ? mtmo + 1 : 0;
            if (p_pop) begin
                pend_data  = exp_q.pop_front();
                pend_valid = 1'b1;
            end
            if (p_push) exp_q.push_back(data_in);
            mcnt = exp_q.size();
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            if (pend_valid) begin
                chk("pop_data", data_out, pend_data);
                pend_valid = 1'b0;
            end
            chk("soft_reset", soft_reset, pend_flush);
            if (pend_flush) begin
                chk("flush_data_out", data_out, 0);
                pend_flush = 1'b0;
            end
            chk("empty", empty, mcnt == 0);
            chk("full", full, mcnt == DEPTH);
            chk("valid_out", valid_out, mcnt != 0);
        end
    end

    task automatic step(input bit we, input bit lfd, input logic [DW-1:0] d, input bit re);
        write_enb = we;
        lfd_state = lfd;
        data_in   = d;
        read_enb  = re;
        @(negedge clock);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_valid_out"}, valid_out, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_soft_reset"}, soft_reset, 0);
        chk({tag, "_pkt_done"}, pkt_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done_seen;
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset  = 1'b0;
        mon_en = 1'b1;

        // Header 0x0C (len 3), three payload bytes, parity, continuous read.
        step(1, 1, 8'h0C, 1);
        step(1, 0, 8'h11, 1);
        step(1, 0, 8'h22, 1);
        step(1, 0, 8'h33, 1);
        step(1, 0, 8'h3C, 1);
        chk("pkt_done_early", pkt_done, 0);
        step(0, 0, 8'h00, 1);
        chk("pkt_done_pulse", pkt_done, 1);
        chk("pkt_parity_out", data_out, 8'h3C);
        step(0, 0, 8'h00, 0);
        chk("pkt_done_width", pkt_done, 0);

        // Zero-length header (low bits ignored): parity only.
        step(1, 1, 8'h03, 1);
        step(1, 0, 8'hAA, 1);
        chk("len0_no_done", pkt_done, 0);
        step(0, 0, 8'h00, 1);
        chk("len0_done", pkt_done, 1);
        step(0, 0, 8'h00, 0);

        // Header inside a packet restarts it.
        step(1, 1, 8'h08, 1);
        step(1, 1, 8'h00, 1);
        step(1, 0, 8'h55, 1);
        chk("restart_no_done", pkt_done, 0);
        step(0, 0, 8'h00, 1);
        chk("restart_done", pkt_done, 1);
        step(0, 0, 8'h00, 0);

        // Fill to full; push while full with concurrent pop is dropped.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h40 + i), 0);
        chk("fill_full", full, 1);
        step(1, 0, 8'hEE, 1);
        chk("drop_full_cleared", full, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 8'h00, 1);
        chk("count15_not_empty", empty, 0);
        step(0, 0, 8'h00, 1);
        chk("count15_empty", empty, 1);
        step(0, 0, 8'h00, 0);

        // Unread byte triggers timeout flush on the 30th idle edge.
        step(1, 0, 8'h5A, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 8'h00, 0);
        chk("tmo_before_soft", soft_reset, 0);
        chk("tmo_before_empty", empty, 0);
        step(0, 0, 8'h00, 0);
        chk("tmo_soft_reset", soft_reset, 1);
        chk("tmo_empty", empty, 1);
        chk("tmo_data_out", data_out, 0);
        step(0, 0, 8'h00, 0);
        chk("tmo_soft_width", soft_reset, 0);

        // Read arriving on the last possible edge prevents the flush.
        step(1, 0, 8'h6B, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        chk("late_read_no_soft", soft_reset, 0);
        chk("late_read_data", data_out, 8'h6B);
        chk("late_read_empty", empty, 1);
        step(0, 0, 8'h00, 0);

        // Interleaved traffic across pointer wrap.
        for (int i = 0; i < 40; i++) step(1, 0, 8'(i * 7 + 3), (i % 3) != 0);
        for (int k = 0; k < 20; k++) if (!empty) step(0, 0, 8'h00, 1);
        chk("interleave_drained", empty, 1);
        step(0, 0, 8'h00, 0);

        // Reset mid-packet: header len 2 popped, five bytes left, pkt_rem=3.
        step(1, 1, 8'h08, 0);
        for (int i = 1; i <= 5; i++) step(1, 0, 8'(8'hA0 + i), 0);
        step(0, 0, 8'h00, 1);
        reset = 1'b1;
        step(0, 0, 8'h00, 0);
        chk_reset_outputs("midpkt_reset");
        reset = 1'b0;
        step(1, 0, 8'hC1, 0);
        step(1, 0, 8'hC2, 0);
        step(1, 0, 8'hC3, 0);
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00, i < 3);
            done_seen = done_seen | pkt_done;
        end
        chk("post_reset_idle_fsm", done_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_dest_fifo.md
ROUTER_DEST_FIFO -- requirements
Module: router_dest_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data byte width; SHALL be >= 4.
REQ-002 Parameter DEPTH, default 16, entry count; SHALL be a power of 2, >= 4.
REQ-003 Parameter TIMEOUT, default 30, unread-cycle limit before soft reset; SHALL be >= 2.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 write_enb  input  1  push data_in this cycle.
REQ-007 lfd_state  input  1  qualifies data_in as packet header byte (first byte).
REQ-008 data_in  input  DATA_W  byte to store.
REQ-009 read_enb  input  1  destination pops one byte.
REQ-010 data_out  output  DATA_W  popped byte, registered.
REQ-011 valid_out  output  1  FIFO holds at least one byte.
REQ-012 full  output  1  FIFO holds DEPTH bytes.
REQ-013 empty  output  1  FIFO holds zero bytes.
REQ-014 soft_reset  output  1  one-cycle pulse: timeout flush occurred.
REQ-015 pkt_done  output  1  one-cycle pulse: last byte (parity) of a packet popped.

Function
REQ-016 Storage SHALL be DEPTH entries of DATA_W+1 bits: data plus header flag (lfd_state captured at push).
REQ-017 Occupancy count SHALL be log2(DEPTH)+1 bits; pointers log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-018 Push SHALL occur when write_enb=1 and full=0; write_enb while full SHALL be ignored, even if read_enb=1 same cycle.
REQ-019 Pop SHALL occur when read_enb=1 and empty=0; read_enb while empty SHALL be ignored, data_out holds.
REQ-020 Simultaneous push and pop SHALL both occur; count unchanged.
REQ-021 Read latency SHALL be 1 cycle: popped entry appears on data_out the cycle after the pop edge and holds until next pop.
REQ-022 valid_out SHALL equal !empty; empty, full SHALL be decoded from registered count (no combinational path from inputs).
REQ-023 Read-side FSM states: RD_IDLE, RD_PKT.
REQ-024 RD_IDLE: pop of header-flagged entry -> RD_PKT, load pkt_rem = data[DATA_W-1:2] + 1 (payload length + parity).
REQ-025 RD_PKT: each pop decrements pkt_rem; pop at pkt_rem=1 -> pkt_done pulses next cycle, return RD_IDLE.
REQ-026 Header of length 0 SHALL load pkt_rem=1 (parity only).
REQ-027 Non-header pop in RD_IDLE SHALL stay RD_IDLE; header pop in RD_PKT SHALL restart packet (reload pkt_rem), no pkt_done.
REQ-028 Timeout counter SHALL increment each cycle valid_out=1 and read_enb=0; clear when read_enb=1 or valid_out=0.
REQ-029 When counter reaches TIMEOUT-1 with condition still true, next edge SHALL flush: count, pointers, pkt_rem, counter := 0, FSM := RD_IDLE, data_out := 0, soft_reset=1 for that one cycle.
REQ-030 Flush SHALL win over a concurrent push or pop; both dropped.

Reset
REQ-031 reset=1 at a clock edge SHALL clear count, pointers, pkt_rem, timeout counter; FSM := RD_IDLE.
REQ-032 After reset: data_out=0, valid_out=0, empty=1, full=0, soft_reset=0, pkt_done=0.
REQ-033 reset SHALL override all other inputs, including mid-packet and mid-timeout; memory contents need not clear.

Verification
REQ-034 Push header 0x0C (len 3), bytes 0x11,0x22,0x33, parity 0x3C; read_enb=1 continuous -> data_out 0x0C,0x11,0x22,0x33,0x3C on successive cycles, pkt_done pulse 1 cycle after parity pop.
REQ-035 Push 16 bytes (DEPTH=16) -> full=1; 17th push with read_enb=1 dropped, pop occurs, count=15.
REQ-036 Push 1 byte, hold read_enb=0 for 30 cycles -> soft_reset=1 on cycle 30 edge, empty=1, data_out=0.
REQ-037 Same as REQ-036 but read_enb=1 at cycle 29 -> no soft_reset, byte popped, counter cleared.
REQ-038 Interleave push/pop with pointers wrapping 15 -> 0 over 40 bytes -> output order matches input order, count never exceeds 16.
REQ-039 Assert reset mid-packet with 5 bytes stored, pkt_rem=3 -> next cycle empty=1, FSM RD_IDLE, all outputs at reset values.
